mux_pipe_reg: RTL and testbench

//   Parametrised successor to the 2:1 mux + 4-bit D register: selects one of
//   NCH input channels and writes it into a DEPTH-stage register pipeline.

---
 rtl/mux_pipe_reg.sv | 91 +++++++++
 tb/tb_mux_pipe_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_reg.sv
// Channel-select mux feeding a DEPTH-stage register pipeline with hold, load,
// shift and rotate modes, plus a saturating count of valid stages.
module mux_pipe_reg #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [SELW-1:0]        sel,
  input  logic [1:0]             mode,
  input  logic                   en,
  output logic [WIDTH-1:0]       q,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [CNTW-1:0]        fill,
  output logic                   full
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_t;

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CNTW-1:0]  r_fill;
  logic [WIDTH-1:0] w_mux;
  logic             w_full;
  mode_t            w_mode;

  assign w_mode = mode_t'(mode);
  assign w_full = (r_fill == CNTW'(DEPTH));

  // Out-of-range selects fall through to zero instead of wrapping.
  always_comb begin
    w_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel == SELW'(c)) begin
        w_mux = din[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
    end else if (en) begin
      case (w_mode)
        MODE_LOAD: begin
          r_stage[0] <= w_mux;
          if (r_fill == '0) begin
            r_fill <= CNTW'(1);
          end
        end
        MODE_SHIFT: begin
          r_stage[0] <= w_mux;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
          if (!w_full) begin
            r_fill <= r_fill + CNTW'(1);
          end
        end
        MODE_ROTATE: begin
          r_stage[0] <= r_stage[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = r_stage[g];
  end

  assign q    = r_stage[DEPTH-1];
  assign fill = r_fill;
  assign full = w_full;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: directed scenarios, then random traffic compared
// against a queue-based model of the pipeline.
module tb_mux_pipe_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [1:0]  mode, sel;
  logic [15:0] din;
  logic [3:0]  q;
  logic [15:0] taps;
  logic [2:0]  fill;
  logic        full;

  logic        rst3, en3;
  logic [1:0]  mode3, sel3;
  logic [11:0] din3;
  logic [3:0]  q3;
  logic [15:0] taps3;
  logic [2:0]  fill3;
  logic        full3;

  mux_pipe_reg #(.WIDTH(4), .NCH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
    .q(q), .taps(taps), .fill(fill), .full(full)
  );

  mux_pipe_reg #(.WIDTH(4), .NCH(3), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst3), .din(din3), .sel(sel3), .mode(mode3), .en(en3),
    .q(q3), .taps(taps3), .fill(fill3), .full(full3)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [3:0] ms[$];
  int         mfill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Stage 0 is the front of the queue, the oldest stage is the back.
  task automatic model_edge();
    logic [3:0] m;
    m = din[sel*4 +: 4];
    if (rst) begin
      ms = '{4'h0, 4'h0, 4'h0, 4'h0};
      mfill = 0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          ms[0] = m;
          if (mfill == 0) mfill = 1;
        end
        2'b10: begin
          ms.push_front(m);
          void'(ms.pop_back());
          mfill = (mfill + 1 > 4) ? 4 : mfill + 1;
        end
        2'b11: ms.push_front(ms.pop_back());
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] et;
    for (int i = 0; i < 4; i++) et[i*4 +: 4] = ms[i];
    check({tag, ".taps"}, 32'(taps), 32'(et));
    check({tag, ".q"},    32'(q),    32'(ms[3]));
    check({tag, ".fill"}, 32'(fill), 32'(mfill));
    check({tag, ".full"}, 32'(full), 32'(mfill == 4));
  endtask

  initial begin
    ms = '{4'h0, 4'h0, 4'h0, 4'h0};
    mfill = 0;
    rst = 1'b1; en = 1'b1; mode = 2'b10; din = 16'hFFFF; sel = 2'd0;
    rst3 = 1'b1; en3 = 1'b0; mode3 = 2'b00; din3 = 12'h000; sel3 = 2'd0;

    // reset while requesting SHIFT of all-ones
    tick();
    check("rst.taps", 32'(taps), 32'h0);
    check("rst.q",    32'(q),    32'h0);
    check("rst.fill", 32'(fill), 32'h0);
    check("rst.full", 32'(full), 32'h0);

    // LOAD from channel 2, then reload
    rst = 1'b0; mode = 2'b01; sel = 2'd2; din = 16'h0A00;
    tick();
    check("load1.taps", 32'(taps), 32'h000A);
    check("load1.fill", 32'(fill), 32'd1);
    din = 16'h0B00;
    tick();
    check("load2.taps", 32'(taps), 32'h000B);
    check("load2.fill", 32'(fill), 32'd1);

    // SHIFT 1..4 through channel 0 from reset
    rst = 1'b1; tick();
    rst = 1'b0; mode = 2'b10; sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      din = 16'(k) | 16'h7770;
      tick();
      check("shift.fill", 32'(fill), 32'(k));
    end
    check("shift4.taps", 32'(taps), 32'h1234);
    check("shift4.q",    32'(q),    32'h1);
    check("shift4.full", 32'(full), 32'h1);

    // ROTATE: one edge, then back round after four
    mode = 2'b11; din = 16'hEEEE;
    tick();
    check("rot1.taps", 32'(taps), 32'h2341);
    check("rot1.q",    32'(q),    32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rot.fill", 32'(fill), 32'd4);
    end
    check("rot4.taps", 32'(taps), 32'h1234);

    // SHIFT at full: oldest discarded, fill saturates
    mode = 2'b10; din = 16'h0005;
    tick();
    check("sat.taps", 32'(taps), 32'h2345);
    check("sat.q",    32'(q),    32'h2);
    check("sat.fill", 32'(fill), 32'd4);
    check("sat.full", 32'(full), 32'h1);

    // HOLD with enable, then enable low with SHIFT requested
    mode = 2'b00; din = 16'h9999;
    tick();
    check("hold.taps", 32'(taps), 32'h2345);
    en = 1'b0; mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      din = 16'($urandom);
      tick();
      check("en0.taps", 32'(taps), 32'h2345);
      check("en0.fill", 32'(fill), 32'd4);
    end

    // NCH=3 build: sel=3 is out of range and must read as zero
    tick();
    rst3 = 1'b0; en3 = 1'b1; mode3 = 2'b01; din3 = 12'hFFF; sel3 = 2'd2;
    tick();
    check("n3.load.taps", 32'(taps3), 32'h000F);
    check("n3.load.fill", 32'(fill3), 32'd1);
    mode3 = 2'b10; sel3 = 2'd3;
    tick();
    check("n3.shift.taps", 32'(taps3), 32'h00F0);
    check("n3.shift.fill", 32'(fill3), 32'd2);
    mode3 = 2'b01;
    tick();
    check("n3.load0.taps", 32'(taps3), 32'h00F0);
    check("n3.load0.q",    32'(q3),    32'h0);
    en3 = 1'b0;

    // reset in the middle of full-speed shifting
    en = 1'b1; mode = 2'b10; sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      din = 16'($urandom);
      tick();
    end
    rst = 1'b1; din = 16'hFFFF;
    tick();
    check("midrst.taps", 32'(taps), 32'h0);
    check("midrst.fill", 32'(fill), 32'h0);
    check("midrst.full", 32'(full), 32'h0);
    rst = 1'b0; din = 16'h0007;
    tick();
    check("postrst.taps", 32'(taps), 32'h0007);
    check("postrst.fill", 32'(fill), 32'd1);

    // random traffic against the queue model
    for (int n = 0; n < 300; n++) begin
      rst  = ($urandom_range(0, 24) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      sel  = 2'($urandom);
      din  = 16'($urandom);
      tick();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
